// File: rtl/sw_debounce.sv
// sw_debounce: five-channel slide-switch synchronizer and debouncer.
// Each switch bit is double-flopped into the CLK domain, then accepted onto
// SW_CLEAN only after it has differed from the accepted level for
// DEBOUNCE_CYCLES consecutive cycles. SW_RISE / SW_FALL are registered
// one-cycle strobes that coincide with the cycle SW_CLEAN takes its new value.
// Build option: define SW_DEBOUNCE_EN to instantiate the per-bit counters;
// without it SW_CLEAN simply follows the synchronizer output each cycle.
module sw_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [4:0] SW,
    output logic [4:0] SW_CLEAN,
    output logic [4:0] SW_RISE,
    output logic [4:0] SW_FALL
);

    localparam int NB = 5;

    // Reject configurations where the counter could not reach its terminal value.
    if (DEBOUNCE_CYCLES < 1 || (64'd1 << CNT_W) < 64'(DEBOUNCE_CYCLES)) begin : g_param_check
        $error("sw_debounce: need DEBOUNCE_CYCLES >= 1 and 2**CNT_W >= DEBOUNCE_CYCLES");
    end

    logic [NB-1:0] r_sync1;
    logic [NB-1:0] r_sync2;
    logic [NB-1:0] r_clean;
    logic [NB-1:0] r_rise;
    logic [NB-1:0] r_fall;
    logic [NB-1:0] w_clean_nxt;

    // Two-flop synchronizer; nothing else looks at SW directly.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= SW;
            r_sync2 <= r_sync1;
        end
    end

`ifdef SW_DEBOUNCE_EN
    // Terminal count: the level is accepted on the edge that sees this value.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt     [NB];
    logic [CNT_W-1:0] w_cnt_nxt [NB];

    // Per-bit STABLE/PENDING decision: count while sync2 disagrees, accept at terminal count.
    always_comb begin
        w_clean_nxt = r_clean;
        for (int i = 0; i < NB; i++) begin
            w_cnt_nxt[i] = '0;
            if (r_sync2[i] != r_clean[i]) begin
                if (r_cnt[i] == CNT_LAST) begin
                    w_clean_nxt[i] = r_sync2[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Independent counter per bit; cleared whenever the bit is stable or accepted.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NB; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NB; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end
`else
    // Debouncing disabled: accept the synchronized level every cycle.
    assign w_clean_nxt = r_sync2;
`endif

    // Accepted level and edge strobes, all registered from the same next-state value.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_clean <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
        end else begin
            r_clean <= w_clean_nxt;
            r_rise  <= w_clean_nxt & ~r_clean;
            r_fall  <= ~w_clean_nxt & r_clean;
        end
    end

    assign SW_CLEAN = r_clean;
    assign SW_RISE  = r_rise;
    assign SW_FALL  = r_fall;

endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboard bench for sw_debounce: a run-length reference model predicts
// {SW_CLEAN, SW_RISE, SW_FALL} for every clock edge, a monitor compares.
module tb_sw_debounce;

`ifdef SW_DEBOUNCE_EN
    localparam int D   = 4;     // cycles a level must persist
    localparam int LAT = 6;     // edges from first sample to SW_CLEAN update
`else
    localparam int D   = 1;
    localparam int LAT = 3;
`endif

    logic       CLK = 1'b0;
    logic       RST;
    logic [4:0] SW;
    logic [4:0] SW_CLEAN;
    logic [4:0] SW_RISE;
    logic [4:0] SW_FALL;

    sw_debounce #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .SW       (SW),
        .SW_CLEAN (SW_CLEAN),
        .SW_RISE  (SW_RISE),
        .SW_FALL  (SW_FALL)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;
    int n_edges  = 0;

    logic [14:0] exp_q[$];

    // Reference model: the two synchronizer samples, accepted level and,
    // per bit, how many consecutive edges the synchronized level has disagreed.
    logic [4:0] m_s1 = '0, m_s2 = '0, m_clean = '0, m_rise = '0, m_fall = '0;
    int         run[5];

    task automatic check(input string name, input logic [14:0] got, input logic [14:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got clean/rise/fall=%b/%b/%b required %b/%b/%b",
                      name, got[14:10], got[9:5], got[4:0], want[14:10], want[9:5], want[4:0]);
    endtask

    task automatic model_edge(input logic r, input logic [4:0] s);
        if (r) begin
            m_s1 = '0; m_s2 = '0; m_clean = '0; m_rise = '0; m_fall = '0;
            for (int i = 0; i < 5; i++) run[i] = 0;
        end else begin
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < 5; i++) begin
                if (m_s2[i] != m_clean[i]) begin
                    run[i] = run[i] + 1;
                    if (run[i] == D) begin
                        m_clean[i] = m_s2[i];
                        if (m_s2[i]) m_rise[i] = 1'b1;
                        else         m_fall[i] = 1'b1;
                        run[i] = 0;
                    end
                end else begin
                    run[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = s;
        end
    endtask

    // One clock: drive at the falling edge, predict, push after the rising edge.
    task automatic step(input logic r, input logic [4:0] s);
        logic [14:0] e;
        RST = r;
        SW  = s;
        #1;
        if (r) check("async_reset", {SW_CLEAN, SW_RISE, SW_FALL}, 15'd0);
        model_edge(r, s);
        e = {m_clean, m_rise, m_fall};
        @(posedge CLK);
        exp_q.push_back(e);
        @(negedge CLK);
    endtask

    // Monitor: every falling edge, compare the DUT against the oldest prediction.
    initial begin
        logic [14:0] e;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_edges++;
                check($sformatf("edge%0d", n_edges), {SW_CLEAN, SW_RISE, SW_FALL}, e);
            end
        end
    end

    initial begin
        logic [4:0] sw_v;
        for (int i = 0; i < 5; i++) run[i] = 0;
        RST = 1'b1;
        SW  = 5'b11111;
        @(negedge CLK);

        // Reset held with all switches up, then release and hold.
        for (int k = 0; k < 3; k++) step(1'b1, 5'b11111);
        for (int k = 1; k <= LAT + 2; k++) begin
            step(1'b0, 5'b11111);
            check($sformatf("release_clean_e%0d", k), {SW_CLEAN, 10'd0},
                  {(k >= LAT) ? 5'b11111 : 5'b00000, 10'd0});
            check($sformatf("release_rise_e%0d", k), {5'd0, SW_RISE, SW_FALL},
                  {5'd0, (k == LAT) ? 5'b11111 : 5'b00000, 5'b00000});
        end

        // All low, then SW[0] alone goes high and holds.
        for (int k = 0; k < 10; k++) step(1'b0, 5'b00000);
        for (int k = 0; k < 10; k++) step(1'b0, 5'b00001);

        // SW[2] pulses of 3 cycles, repeated.
        for (int rep = 0; rep < 5; rep++) begin
            for (int k = 0; k < 3; k++) step(1'b0, 5'b00101);
            for (int k = 0; k < 3; k++) step(1'b0, 5'b00001);
        end
`ifdef SW_DEBOUNCE_EN
        check("glitch_sw2", {SW_CLEAN[2], SW_RISE[2], SW_FALL[2], 12'd0}, 15'd0);
`endif

        // SW[1], SW[4] high; both fall together, SW[4] bounces once.
        for (int k = 0; k < 10; k++) step(1'b0, 5'b10011);
        step(1'b0, 5'b00001);
        step(1'b0, 5'b00001);
        step(1'b0, 5'b10001);
        for (int k = 0; k < 10; k++) step(1'b0, 5'b00001);

        // SW[3] rises; reset pulses mid-count, then the count restarts.
        step(1'b0, 5'b01001);
        step(1'b0, 5'b01001);
        step(1'b0, 5'b01001);
        step(1'b0, 5'b01001);
        step(1'b1, 5'b01001);
        for (int k = 0; k < 10; k++) step(1'b0, 5'b01001);

        // SW[0] toggled every 2 cycles.
        sw_v = 5'b00000;
        for (int k = 0; k < 16; k++) begin
            if (k % 2 == 0) sw_v[0] = ~sw_v[0];
            step(1'b0, sw_v);
        end

        // Randomized bouncing on all bits with occasional resets.
        for (int c = 0; c < 2000; c++) begin
            logic [4:0] flip;
            for (int i = 0; i < 5; i++) flip[i] = ($urandom_range(0, 9) == 0);
            sw_v = sw_v ^ flip;
            step(($urandom_range(0, 399) == 0), sw_v);
        end
        for (int k = 0; k < 10; k++) step(1'b0, sw_v);

        @(negedge CLK);
        check("scoreboard_drained", {10'd0, 5'(exp_q.size())}, 15'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
